// File: rtl/game_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer_pkg
//  Description : Shared state encodings, coordinate width and datapath defaults
//  Revision    : 1.0 - initial release
// ============================================================================
package game_sequencer_pkg;

    localparam int c_COORD_W      = 9;
    localparam int c_DIFF_W       = c_COORD_W + 1;
    localparam int c_DEF_TICK_DIV = 10_000_000;
    localparam int c_DEF_LIVES    = 3;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_PLAY = 2'd1;
    localparam logic [1:0] c_ST_HIT  = 2'd2;
    localparam logic [1:0] c_ST_OVER = 2'd3;

    // Magnitude of a-b computed one bit wider so it can never wrap.
    function automatic logic [c_DIFF_W-1:0] abs_diff(
        input logic [c_COORD_W-1:0] a,
        input logic [c_COORD_W-1:0] b
    );
        logic [c_DIFF_W-1:0] w_a;
        logic [c_DIFF_W-1:0] w_b;
        w_a = {1'b0, a};
        w_b = {1'b0, b};
        return (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer_tick_gen
//  Description : Free-running divider producing a 1-cycle game tick
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer_tick_gen
    import game_sequencer_pkg::*;
#(
    parameter int TICK_DIV = c_DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                 c_CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : game_sequencer
//  Description : Game FSM: button edges, collision, score/lives and movement strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int TICK_DIV     = c_DEF_TICK_DIV,
    parameter int ENEMY_DIV    = 4,
    parameter int BULLET_Y_MAX = 400,
    parameter int ENEMY_Y_MIN  = 40,
    parameter int HIT_W        = 16,
    parameter int HIT_H        = 16,
    parameter int HIT_HOLD     = 8,
    parameter int LIVES        = c_DEF_LIVES,
    parameter int SCORE_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 fire,
    input  logic [c_COORD_W-1:0] bullet_x,
    input  logic [c_COORD_W-1:0] bullet_y,
    input  logic                 bullet_live,
    input  logic [c_COORD_W-1:0] enemy_x,
    input  logic [c_COORD_W-1:0] enemy_y,
    output logic                 tick,
    output logic                 fire_pulse,
    output logic                 bullet_step,
    output logic                 bullet_kill,
    output logic                 enemy_step,
    output logic                 enemy_respawn,
    output logic [SCORE_W-1:0]   score,
    output logic [1:0]           lives,
    output logic [1:0]           state,
    output logic                 game_over
);

    localparam int                   c_ENEMY_W      = (ENEMY_DIV > 1) ? $clog2(ENEMY_DIV) : 1;
    localparam int                   c_HOLD_W       = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
    localparam logic [c_ENEMY_W-1:0] c_ENEMY_LAST   = c_ENEMY_W'(ENEMY_DIV - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST    = c_HOLD_W'(HIT_HOLD - 1);
    localparam logic [c_COORD_W-1:0] c_BULLET_Y_MAX = c_COORD_W'(BULLET_Y_MAX);
    localparam logic [c_COORD_W-1:0] c_ENEMY_Y_MIN  = c_COORD_W'(ENEMY_Y_MIN);
    localparam logic [c_DIFF_W-1:0]  c_HIT_W        = c_DIFF_W'(HIT_W);
    localparam logic [c_DIFF_W-1:0]  c_HIT_H        = c_DIFF_W'(HIT_H);
    localparam logic [1:0]           c_LIVES        = 2'(LIVES);

    logic                 w_tick;
    logic                 w_start_e;
    logic                 w_fire_e;
    logic                 w_hit_event;
    logic                 w_bullet_out;
    logic                 w_enemy_low;
    logic                 w_enemy_wrap;

    logic                 r_start_q;
    logic                 r_fire_q;
    logic [1:0]           r_state;
    logic [c_ENEMY_W-1:0] r_enemy_cnt;
    logic [c_HOLD_W-1:0]  r_hold_cnt;
    logic [SCORE_W-1:0]   r_score;
    logic [1:0]           r_lives;
    logic                 r_fire_pulse;
    logic                 r_bullet_step;
    logic                 r_bullet_kill;
    logic                 r_enemy_step;
    logic                 r_enemy_respawn;

    game_sequencer_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    assign w_start_e    = start & ~r_start_q;
    assign w_fire_e     = fire & ~r_fire_q;
    assign w_hit_event  = bullet_live
                        && (abs_diff(bullet_x, enemy_x) < c_HIT_W)
                        && (abs_diff(bullet_y, enemy_y) < c_HIT_H);
    assign w_bullet_out = bullet_live && (bullet_y >= c_BULLET_Y_MAX);
    assign w_enemy_low  = (enemy_y <= c_ENEMY_Y_MIN);
    assign w_enemy_wrap = (r_enemy_cnt == c_ENEMY_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_q       <= 1'b0;
            r_fire_q        <= 1'b0;
            r_state         <= c_ST_IDLE;
            r_enemy_cnt     <= '0;
            r_hold_cnt      <= '0;
            r_score         <= '0;
            r_lives         <= 2'd0;
            r_fire_pulse    <= 1'b0;
            r_bullet_step   <= 1'b0;
            r_bullet_kill   <= 1'b0;
            r_enemy_step    <= 1'b0;
            r_enemy_respawn <= 1'b0;
        end else begin
            r_start_q       <= start;
            r_fire_q        <= fire;
            r_fire_pulse    <= 1'b0;
            r_bullet_step   <= 1'b0;
            r_bullet_kill   <= 1'b0;
            r_enemy_step    <= 1'b0;
            r_enemy_respawn <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start_e) begin
                        r_state         <= c_ST_PLAY;
                        r_score         <= '0;
                        r_lives         <= c_LIVES;
                        r_enemy_cnt     <= '0;
                        r_enemy_respawn <= 1'b1;
                    end
                end
                c_ST_PLAY: begin
                    // A press while a bullet is in flight is simply lost.
                    if (w_fire_e && !bullet_live) begin
                        r_fire_pulse <= 1'b1;
                    end
                    if (w_tick) begin
                        r_enemy_cnt <= w_enemy_wrap ? '0 : r_enemy_cnt + 1'b1;
                        if (w_hit_event) begin
                            r_bullet_kill   <= 1'b1;
                            r_enemy_respawn <= 1'b1;
                            r_score         <= (&r_score) ? r_score : r_score + 1'b1;
                            r_hold_cnt      <= '0;
                            r_state         <= c_ST_HIT;
                        end else begin
                            if (w_bullet_out) begin
                                r_bullet_kill <= 1'b1;
                            end else if (bullet_live) begin
                                r_bullet_step <= 1'b1;
                            end
                            if (w_enemy_wrap) begin
                                r_enemy_step <= 1'b1;
                            end
                            if (w_enemy_low) begin
                                r_enemy_respawn <= 1'b1;
                                r_lives         <= r_lives - 2'd1;
                                r_enemy_cnt     <= '0;
                                if (r_lives == 2'd1) begin
                                    r_state <= c_ST_OVER;
                                end
                            end
                        end
                    end
                end
                c_ST_HIT: begin
                    if (w_tick) begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state <= c_ST_PLAY;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end
                c_ST_OVER: begin
                    if (w_start_e) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign tick          = w_tick;
    assign fire_pulse    = r_fire_pulse;
    assign bullet_step   = r_bullet_step;
    assign bullet_kill   = r_bullet_kill;
    assign enemy_step    = r_enemy_step;
    assign enemy_respawn = r_enemy_respawn;
    assign score         = r_score;
    assign lives         = r_lives;
    assign state         = r_state;
    assign game_over     = (r_state == c_ST_OVER);

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_sequencer
//  Description : Directed self-checking bench for game_sequencer
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       fire;
    logic [8:0] bullet_x;
    logic [8:0] bullet_y;
    logic       bullet_live;
    logic [8:0] enemy_x;
    logic [8:0] enemy_y;
    logic       tick;
    logic       fire_pulse;
    logic       bullet_step;
    logic       bullet_kill;
    logic       enemy_step;
    logic       enemy_respawn;
    logic [7:0] score;
    logic [1:0] lives;
    logic [1:0] state;
    logic       game_over;

    int n_checks = 0;
    int n_errors = 0;

    game_sequencer #(
        .TICK_DIV  (4),
        .ENEMY_DIV (2),
        .HIT_HOLD  (2),
        .LIVES     (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .fire          (fire),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_live   (bullet_live),
        .enemy_x       (enemy_x),
        .enemy_y       (enemy_y),
        .tick          (tick),
        .fire_pulse    (fire_pulse),
        .bullet_step   (bullet_step),
        .bullet_kill   (bullet_kill),
        .enemy_step    (enemy_step),
        .enemy_respawn (enemy_respawn),
        .score         (score),
        .lives         (lives),
        .state         (state),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench inside a tick cycle; a missing tick counts as a failure.
    task automatic wait_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        n_checks++;
        assert (tick === 1'b1) else begin
            n_errors++;
            $error("FAIL wait_tick: observed %0d expected 1", tick);
        end
    endtask

    task automatic set_pos(input int bx, input int by, input int ex, input int ey, input logic live);
        bullet_x    = 9'(bx);
        bullet_y    = 9'(by);
        enemy_x     = 9'(ex);
        enemy_y     = 9'(ey);
        bullet_live = live;
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        logic [1:0] prev_state;

        rst = 1'b1; start = 1'b0; fire = 1'b0;
        set_pos(0, 0, 300, 300, 1'b0);

        // 1: reset and first tick
        repeat (3) step();
        rst = 1'b0;
        check("rst_state", 32'(state), 0);
        check("rst_score", 32'(score), 0);
        check("rst_lives", 32'(lives), 0);
        check("rst_strobes", 32'({tick, fire_pulse, bullet_step, bullet_kill,
                                  enemy_step, enemy_respawn, game_over}), 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check("first_tick", 32'(tick), (i == 3) ? 1 : 0);
        end

        // 2: held start gives one game start
        start = 1'b1;
        step();
        check("start_state", 32'(state), 1);
        check("start_respawn", 32'(enemy_respawn), 1);
        cnt_a = 1; cnt_b = 1; prev_state = state;
        for (int i = 0; i < 9; i++) begin
            step();
            cnt_a += 32'(enemy_respawn);
            if (state !== prev_state) cnt_b++;
            prev_state = state;
        end
        start = 1'b0;
        check("start_respawn_cnt", 32'(cnt_a), 1);
        check("start_transitions", 32'(cnt_b), 1);
        check("start_lives", 32'(lives), 3);
        check("start_score", 32'(score), 0);

        // 3: held fire gives one pulse; fire with live bullet is dropped
        fire = 1'b1; cnt_a = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt_a += 32'(fire_pulse);
        end
        fire = 1'b0;
        check("fire_once", 32'(cnt_a), 1);
        step();
        set_pos(100, 200, 300, 300, 1'b1);
        fire = 1'b1; cnt_a = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            cnt_a += 32'(fire_pulse);
        end
        fire = 1'b0;
        check("fire_dropped", 32'(cnt_a), 0);

        // enemy steps every second tick
        bullet_live = 1'b0; cnt_a = 0;
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            step();
            cnt_a += 32'(enemy_step);
        end
        check("enemy_step_cnt", 32'(cnt_a), 2);

        // bullet row limit and collision window edges
        set_pos(100, 400, 300, 300, 1'b1);
        wait_tick(); step();
        check("ymax_kill", 32'({bullet_kill, bullet_step}), 2);
        set_pos(100, 399, 300, 300, 1'b1);
        wait_tick(); step();
        check("below_ymax_step", 32'({bullet_kill, bullet_step}), 1);
        set_pos(100, 200, 116, 200, 1'b1);
        wait_tick(); step();
        check("dx16_nohit", 32'({state, bullet_step}), 3);

        // 4: hit, then HIT hold of two ticks
        set_pos(100, 200, 110, 210, 1'b1);
        wait_tick(); step();
        check("hit_strobes", 32'({bullet_kill, enemy_respawn, bullet_step, enemy_step}), 12);
        check("hit_score", 32'(score), 1);
        check("hit_state", 32'(state), 2);
        set_pos(100, 200, 300, 300, 1'b1);
        wait_tick(); step();
        check("hold1_state", 32'(state), 2);
        check("hold1_nostep", 32'(bullet_step), 0);
        wait_tick(); step();
        check("hold2_state", 32'(state), 1);
        check("hold2_nostep", 32'(bullet_step), 0);

        // 6a: hit beats enemy-at-limit (enemy left of bullet)
        set_pos(100, 40, 85, 30, 1'b1);
        wait_tick(); step();
        check("hitlow_score", 32'(score), 2);
        check("hitlow_lives", 32'(lives), 3);
        check("hitlow_state", 32'(state), 2);
        bullet_live = 1'b0;
        wait_tick(); step();
        wait_tick(); step();
        check("hitlow_back", 32'(state), 1);

        // 5: enemy at limit costs lives until game over
        set_pos(100, 200, 300, 40, 1'b0);
        wait_tick(); step();
        check("low1", 32'({state, lives, enemy_respawn}), 32'b01_10_1);
        wait_tick(); step();
        check("low2", 32'({state, lives, enemy_respawn}), 32'b01_01_1);
        wait_tick(); step();
        check("low3", 32'({state, lives, game_over}), 32'b11_00_1);
        wait_tick(); step();
        check("over_frozen", 32'({state, lives, score}), 32'b11_00_00000010);
        start = 1'b1; step(); start = 1'b0;
        check("over_to_idle", 32'({state, game_over}), 0);
        check("idle_score_kept", 32'(score), 2);
        step();
        start = 1'b1; step(); start = 1'b0;
        check("restart", 32'({state, lives, score}), 32'b01_11_00000000);

        // 6b: reset in the middle of HIT
        set_pos(100, 200, 110, 210, 1'b1);
        wait_tick(); step();
        check("hit2_state", 32'({state, bullet_kill, enemy_respawn}), 32'b10_1_1);
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_state", 32'({state, score, lives}), 0);
        check("midrst_strobes", 32'({tick, bullet_kill, enemy_respawn, game_over}), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
